// File: rtl/ft_alu_seq.sv
// Fault-tolerant ALU sequencer: drives a duplicated external ALU,
// cross-checks both channels and retries on disagreement.
module ft_alu_seq #(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_a,
  input  logic [2:0]       req_b,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [1:0]       rsp_retries,
  output logic [2:0]       alu_a,
  output logic [2:0]       alu_b,
  output logic             alu_par,
  output logic [2:0]       alu_c,
  input  logic [2:0]       alu_x,
  input  logic             alu_xc,
  input  logic [1:0]       alu_xe,
  input  logic [2:0]       alu_y,
  input  logic             alu_yc,
  input  logic [1:0]       alu_ye,
  output logic [CNT_W-1:0] err_count,
  output logic             fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  state_t r_state;
  state_t w_next;

  logic             r_ready;
  logic             r_valid;
  logic [2:0]       r_sum;
  logic             r_carry;
  logic             r_err;
  logic [1:0]       r_retries;
  logic [2:0]       r_alu_a;
  logic [2:0]       r_alu_b;
  logic             r_alu_par;
  logic [2:0]       r_alu_c;
  logic [CNT_W-1:0] r_err_count;
  logic             r_fault;

  logic       w_hs;
  logic       w_legal;
  logic       w_pass;
  logic       w_can_retry;
  logic       w_load;
  logic       w_ill;
  logic       w_eval;
  logic       w_fail;
  logic       w_exhaust;
  logic [2:0] w_onehot;

  assign w_hs        = req_valid & r_ready;
  assign w_legal     = (req_op != 2'b11);
  assign w_can_retry = (r_retries < RETRY_MAX);

  // Both channels must report healthy and agree on carry and result.
  assign w_pass = (alu_xe == 2'b10) &&
                  (alu_ye == 2'b10) &&
                  ({alu_xc, alu_x} == {alu_yc, alu_y});

  always_comb begin
    w_onehot = 3'b000;
    unique case (req_op)
      2'b00:   w_onehot = 3'b001;
      2'b01:   w_onehot = 3'b010;
      2'b10:   w_onehot = 3'b100;
      default: w_onehot = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next = w_legal ? S_EVAL : S_RESP;
        end
      end
      S_EVAL: begin
        if (w_pass || !w_can_retry) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_ill     = 1'b0;
    w_eval    = 1'b0;
    w_fail    = 1'b0;
    w_exhaust = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_load = w_hs & w_legal;
        w_ill  = w_hs & ~w_legal;
      end
      S_EVAL: begin
        w_eval    = 1'b1;
        w_fail    = ~w_pass;
        w_exhaust = ~w_pass & ~w_can_retry;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_valid     <= 1'b0;
      r_sum       <= 3'b000;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_retries   <= 2'b00;
      r_alu_a     <= 3'b000;
      r_alu_b     <= 3'b000;
      r_alu_par   <= 1'b0;
      r_alu_c     <= 3'b000;
      r_err_count <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_valid <= (w_next == S_RESP);
      if (w_load) begin
        r_alu_a   <= req_a;
        r_alu_b   <= req_b;
        r_alu_par <= ~(^req_a ^ ^req_b);
        r_alu_c   <= w_onehot;
        r_retries <= 2'b00;
      end
      if (w_ill) begin
        r_sum     <= 3'b000;
        r_carry   <= 1'b0;
        r_err     <= 1'b1;
        r_retries <= 2'b00;
      end
      if (w_eval && w_pass) begin
        r_sum   <= alu_x;
        r_carry <= alu_xc;
        r_err   <= 1'b0;
        r_alu_c <= 3'b000;
      end
      if (w_fail) begin
        if (r_err_count != {CNT_W{1'b1}}) begin
          r_err_count <= r_err_count + 1'b1;
        end
        if (w_can_retry) begin
          r_retries <= r_retries + 2'd1;
        end
      end
      // Out of retries: report the X channel but flag it untrusted.
      if (w_exhaust) begin
        r_sum   <= alu_x;
        r_carry <= alu_xc;
        r_err   <= 1'b1;
        r_fault <= 1'b1;
        r_alu_c <= 3'b000;
      end
    end
  end

  assign req_ready   = r_ready;
  assign rsp_valid   = r_valid;
  assign rsp_sum     = r_sum;
  assign rsp_carry   = r_carry;
  assign rsp_err     = r_err;
  assign rsp_retries = r_retries;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_par     = r_alu_par;
  assign alu_c       = r_alu_c;
  assign err_count   = r_err_count;
  assign fault       = r_fault;

endmodule

// File: tb/tb_ft_alu_seq.sv
// Directed bench for ft_alu_seq with a behavioural duplicated ALU
// whose channels can be corrupted on demand.
module tb_ft_alu_seq;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic [1:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_sum;
  logic       rsp_carry;
  logic       rsp_err;
  logic [1:0] rsp_retries;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic       alu_par;
  logic [2:0] alu_c;
  logic [2:0] alu_x;
  logic       alu_xc;
  logic [1:0] alu_xe;
  logic [2:0] alu_y;
  logic       alu_yc;
  logic [1:0] alu_ye;
  logic [7:0] err_count;
  logic       fault;

  int n_tests;
  int n_fail;

  logic inj_xe;
  logic inj_ymis;
  logic [3:0] m_res;

  ft_alu_seq #(.MAX_RETRY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .rsp_retries(rsp_retries),
    .alu_a(alu_a), .alu_b(alu_b), .alu_par(alu_par), .alu_c(alu_c),
    .alu_x(alu_x), .alu_xc(alu_xc), .alu_xe(alu_xe),
    .alu_y(alu_y), .alu_yc(alu_yc), .alu_ye(alu_ye),
    .err_count(err_count), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_res = 4'd0;
    unique case (alu_c)
      3'b001:  m_res = {1'b0, alu_a} + {1'b0, alu_b};
      3'b010:  m_res = {1'b0, alu_a} + {1'b0, ~alu_b} + 4'd1;
      3'b100:  m_res = {1'b0, alu_b} + {1'b0, ~alu_a} + 4'd1;
      default: m_res = 4'd0;
    endcase
  end

  assign alu_x  = m_res[2:0];
  assign alu_xc = m_res[3];
  assign alu_xe = inj_xe ? 2'b11 : 2'b10;
  assign alu_y  = inj_ymis ? (m_res[2:0] ^ 3'b001) : m_res[2:0];
  assign alu_yc = m_res[3];
  assign alu_ye = 2'b10;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] a, input logic [2:0] b,
                     input logic [1:0] op, output int lat,
                     output int evals, output logic [2:0] c_seen);
    lat    = 0;
    evals  = 0;
    c_seen = 3'b000;
    req_a  = a;
    req_b  = b;
    req_op = op;
    req_valid = 1'b1;
    chk("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      if (alu_c != 3'b000) evals++;
      c_seen = c_seen | alu_c;
      @(posedge clk); #1;
      lat++;
      inj_xe = 1'b0;
    end
    c_seen = c_seen | alu_c;
  endtask

  task automatic retire();
    @(posedge clk); #1;
    chk("retire_valid", rsp_valid, 0);
    chk("retire_ready", req_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int lat;
  int evals;
  logic [2:0] cs;
  logic [7:0] snap;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    inj_xe    = 1'b0;
    inj_ymis  = 1'b0;
    req_valid = 1'b0;
    req_a     = 3'd0;
    req_b     = 3'd0;
    req_op    = 2'd0;
    rsp_ready = 1'b1;
    do_reset();

    chk("rst_ready", req_ready, 0);
    chk("rst_outs", {rsp_valid, rsp_sum, rsp_carry, rsp_err,
                     rsp_retries, alu_a, alu_b, alu_par, alu_c,
                     err_count, fault}, 0);
    @(posedge clk); #1;
    chk("idle_ready", req_ready, 1);

    run(3'd3, 3'd2, 2'b00, lat, evals, cs);
    chk("add_lat", lat, 2);
    chk("add_c", cs, 3'b001);
    chk("add_a", alu_a, 3);
    chk("add_par", alu_par, 0);
    chk("add_rsp", {rsp_sum, rsp_carry, rsp_err, rsp_retries}, {3'd5, 1'b0, 1'b0, 2'd0});
    retire();

    run(3'd5, 3'd3, 2'b01, lat, evals, cs);
    chk("sub_c", cs, 3'b010);
    chk("sub_par", alu_par, 1);
    chk("sub_rsp", {rsp_sum, rsp_carry, rsp_err}, {3'd2, 1'b1, 1'b0});
    retire();

    run(3'd1, 3'd1, 2'b10, lat, evals, cs);
    chk("rsub_c", cs, 3'b100);
    chk("rsub_rsp", {rsp_sum, rsp_carry, rsp_err}, {3'd0, 1'b1, 1'b0});
    retire();

    inj_xe = 1'b1;
    run(3'd6, 3'd4, 2'b00, lat, evals, cs);
    chk("tr_lat", lat, 3);
    chk("tr_evals", evals, 2);
    chk("tr_rsp", {rsp_sum, rsp_carry, rsp_err, rsp_retries}, {3'd2, 1'b1, 1'b0, 2'd1});
    chk("tr_errcnt", err_count, 1);
    chk("tr_fault", fault, 0);
    retire();

    do_reset();
    @(posedge clk); #1;
    inj_ymis = 1'b1;
    run(3'd2, 3'd1, 2'b00, lat, evals, cs);
    inj_ymis = 1'b0;
    chk("pm_lat", lat, 4);
    chk("pm_evals", evals, 3);
    chk("pm_rsp", {rsp_sum, rsp_carry, rsp_err, rsp_retries}, {3'd3, 1'b0, 1'b1, 2'd2});
    chk("pm_errcnt", err_count, 3);
    chk("pm_fault", fault, 1);
    chk("pm_c_idle", alu_c, 0);
    retire();

    run(3'd4, 3'd4, 2'b11, lat, evals, cs);
    chk("ill_lat", lat, 1);
    chk("ill_c", cs, 3'b000);
    chk("ill_rsp", {rsp_sum, rsp_carry, rsp_err, rsp_retries}, {3'd0, 1'b0, 1'b1, 2'd0});
    chk("ill_errcnt", err_count, 3);
    retire();

    rsp_ready = 1'b0;
    run(3'd4, 3'd1, 2'b01, lat, evals, cs);
    snap = {1'b0, rsp_sum, rsp_carry, rsp_err, rsp_retries};
    chk("bp_first", snap, {1'b0, 3'd3, 1'b1, 1'b0, 2'd0});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", {1'b0, rsp_sum, rsp_carry, rsp_err, rsp_retries}, snap);
      chk("bp_hold", {rsp_valid, req_ready}, 2'b10);
    end
    rsp_ready = 1'b1;
    retire();

    req_a = 3'd7;
    req_b = 3'd7;
    req_op = 2'b00;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_eval_c", alu_c, 3'b001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_outs", {req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_err,
                         rsp_retries, alu_a, alu_b, alu_par, alu_c,
                         err_count, fault}, 0);
    @(posedge clk); #1;
    chk("mid_rst_idle", {req_ready, rsp_valid}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
